// File: rtl/sequence_generator.sv
// Programmable serial pattern transmitter: shifts a latched pattern out MSB-first,
// repeating it repeat_cnt+1 times with an optional idle gap between copies.
module sequence_generator #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [7:0]       repeat_cnt,
  input  logic [3:0]       gap_len,
  input  logic             hold,
  output logic             out_bit,
  output logic             out_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q, idx, idx_n;
  logic [3:0]       gap_q, gc, gc_n;
  logic [8:0]       cp, cp_n;
  logic             load;
  logic             ob_n, ov_n, lb_n, busy_n, done_n, err_n;

  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
    logic [PAT_W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // State registers track what is being presented this cycle; idx is the bit
  // currently shown, so a stall never consumes a bit and release shows idx-1.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cp_n    = cp;
    gc_n    = gc;
    load    = 1'b0;
    ob_n    = 1'b0;
    ov_n    = 1'b0;
    lb_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (pat_len != '0 && pat_len <= MAX_LEN) begin
            load    = 1'b1;
            state_n = SEND;
            idx_n   = pat_len - 1'b1;
            cp_n    = {1'b0, repeat_cnt};
            busy_n  = 1'b1;
            ov_n    = 1'b1;
            ob_n    = bit_at(pattern, pat_len - 1'b1);
            lb_n    = (pat_len == LEN_W'(1));
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SEND: begin
        busy_n = 1'b1;
        if (hold) begin
          ob_n = out_bit;
        end else if (idx != '0) begin
          idx_n = idx - 1'b1;
          ov_n  = 1'b1;
          ob_n  = bit_at(pat_q, idx - 1'b1);
          lb_n  = (idx == LEN_W'(1));
        end else if (cp != '0) begin
          if (gap_q != '0) begin
            state_n = GAP;
            gc_n    = gap_q;
          end else begin
            idx_n = len_q - 1'b1;
            cp_n  = cp - 9'd1;
            ov_n  = 1'b1;
            ob_n  = bit_at(pat_q, len_q - 1'b1);
            lb_n  = (len_q == LEN_W'(1));
          end
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (hold) begin
          ob_n = out_bit;
        end else if (gc == 4'd1) begin
          state_n = SEND;
          gc_n    = '0;
          idx_n   = len_q - 1'b1;
          cp_n    = cp - 9'd1;
          ov_n    = 1'b1;
          ob_n    = bit_at(pat_q, len_q - 1'b1);
          lb_n    = (len_q == LEN_W'(1));
        end else begin
          gc_n = gc - 4'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cp        <= '0;
      gc        <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      last_bit  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cp        <= cp_n;
      gc        <= gc_n;
      if (load) begin
        pat_q <= pattern;
        len_q <= pat_len;
        gap_q <= gap_len;
      end
      out_bit   <= ob_n;
      out_valid <= ov_n;
      last_bit  <= lb_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: table of transfers, expected per-cycle outputs
// built from a behavioural model into a queue and compared cycle by cycle.
module tb_sequence_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  pat_len = '0;
  logic [7:0]  repeat_cnt = '0;
  logic [3:0]  gap_len = '0;
  logic        hold = 1'b0;
  logic        out_bit, out_valid, last_bit, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  // {out_valid, out_bit, last_bit, busy, done, err}
  logic [5:0] exp_q[$];

  typedef struct {
    logic [15:0] pat;
    int len, rep, gap;
    int hk, hn;        // hold hn cycles right after the hk-th valid bit (hn=0: none)
    int xs;            // cycle index of a stray start + input scramble (-1: none)
    int exp_valid, exp_last;
  } vec_t;

  vec_t tbl[11];

  sequence_generator #(.PAT_W(16), .LEN_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .pat_len(pat_len),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len), .hold(hold),
    .out_bit(out_bit), .out_valid(out_valid), .last_bit(last_bit),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {out_valid, out_bit, last_bit, busy, done, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic xfer(input vec_t v, input string tag);
    int hs, nv, nvalid, nlast, n;
    logic b;
    exp_q.delete();
    hs = -1;
    nv = 0;
    if (v.len < 1 || v.len > 16) begin
      exp_q.push_back(6'b000001);
      exp_q.push_back(6'b000000);
    end else begin
      for (int c = 0; c <= v.rep; c++) begin
        for (int k = v.len - 1; k >= 0; k--) begin
          b = v.pat[k];
          exp_q.push_back({1'b1, b, k == 0, 1'b1, 1'b0, 1'b0});
          nv++;
          if (v.hn > 0 && nv == v.hk) begin
            hs = exp_q.size() - 1;
            repeat (v.hn) exp_q.push_back({1'b0, b, 1'b0, 1'b1, 1'b0, 1'b0});
          end
        end
        if (c < v.rep) repeat (v.gap) exp_q.push_back(6'b000100);
      end
      exp_q.push_back(6'b000110);
      exp_q.push_back(6'b000000);
    end
    @(posedge clk); #1;
    pattern    = v.pat;
    pat_len    = 5'(v.len);
    repeat_cnt = 8'(v.rep);
    gap_len    = 4'(v.gap);
    start      = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    n      = exp_q.size();
    nvalid = 0;
    nlast  = 0;
    for (int c = 0; c < n; c++) begin
      hold = (hs >= 0 && c >= hs && c < hs + v.hn);
      if (c == v.xs) begin
        start   = 1'b1;
        pattern = ~pattern;
        pat_len = 5'd3;
        gap_len = 4'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s_cyc%0d", tag, c), 32'(outs()), 32'(exp_q.pop_front()));
      nvalid += int'(out_valid);
      nlast  += int'(out_valid & last_bit);
      @(posedge clk); #1;
    end
    hold  = 1'b0;
    start = 1'b0;
    check({tag, "_nvalid"}, 32'(nvalid), 32'(v.exp_valid));
    check({tag, "_nlast"},  32'(nlast),  32'(v.exp_last));
  endtask

  initial begin
    tbl[0]  = '{16'h000B, 4,   0, 0, 0, 0, -1,   4,   1};  // single copy
    tbl[1]  = '{16'h000B, 4,   1, 0, 0, 0, -1,   8,   2};  // back-to-back
    tbl[2]  = '{16'h0005, 3,   1, 2, 0, 0, -1,   6,   2};  // gap insertion
    tbl[3]  = '{16'h000B, 4,   0, 0, 2, 3, -1,   4,   1};  // hold after 2nd bit
    tbl[4]  = '{16'h000B, 0,   0, 0, 0, 0, -1,   0,   0};  // illegal len 0
    tbl[5]  = '{16'h000B, 17,  0, 0, 0, 0, -1,   0,   0};  // illegal len 17
    tbl[6]  = '{16'h000B, 4,   1, 0, 0, 0, 2,    8,   2};  // stray start mid-transfer
    tbl[7]  = '{16'hA5C3, 16,  2, 1, 0, 0, -1,  48,   3};  // full width
    tbl[8]  = '{16'h0001, 1,   3, 0, 0, 0, -1,   4,   4};  // one-bit pattern
    tbl[9]  = '{16'h1234, 5,   1, 3, 5, 2, -1,  10,   2};  // hold on last bit before gap
    tbl[10] = '{16'h0001, 1, 255, 0, 0, 0, -1, 256, 256};  // 256 copies

    #12;
    check("reset_outputs", 32'(outs()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'(outs()), 32'd0);

    for (int i = 0; i < 11; i++) xfer(tbl[i], $sformatf("vec%0d", i));

    // Abort: asynchronous reset between edges mid-SEND
    @(posedge clk); #1;
    pattern = 16'hA5C3; pat_len = 5'd16; repeat_cnt = 8'd0; gap_len = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    check("abort_mid_send_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_outputs_immediate", 32'(outs()), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_hold_cyc%0d", c), 32'(outs()), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_no_done_cyc%0d", c), 32'(outs()), 32'd0);
    end
    xfer(tbl[0], "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
